// File: rtl/time_disp_pkg.sv
// Shared types and constants for the time/date seven-segment display driver.
package time_disp_pkg;

  // Digit codes: 0-9 are decimal digits, plus the two non-numeric glyphs.
  typedef logic [4:0] digit_t;
  localparam digit_t DIG_DASH  = 5'd10;
  localparam digit_t DIG_BLANK = 5'd11;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_t;

  // Conversion order through the shared BCD engine.
  localparam logic [2:0] FLD_SS = 3'd0;
  localparam logic [2:0] FLD_MM = 3'd1;
  localparam logic [2:0] FLD_HH = 3'd2;
  localparam logic [2:0] FLD_DD = 3'd3;
  localparam logic [2:0] FLD_MO = 3'd4;
  localparam logic [2:0] FLD_YY = 3'd5;

  function automatic logic [6:0] seg_of(digit_t d);
    unique case (d)
      5'd0:    seg_of = 7'h40;
      5'd1:    seg_of = 7'h79;
      5'd2:    seg_of = 7'h24;
      5'd3:    seg_of = 7'h30;
      5'd4:    seg_of = 7'h19;
      5'd5:    seg_of = 7'h12;
      5'd6:    seg_of = 7'h02;
      5'd7:    seg_of = 7'h78;
      5'd8:    seg_of = 7'h00;
      5'd9:    seg_of = 7'h10;
      DIG_DASH: seg_of = SEG_DASH;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, 16-bit input, 5 BCD nibbles.
// 8-bit operands are left-aligned so they finish in 8 shifts.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wide,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] sh_q;
  logic [19:0] bcd_q;
  logic [4:0]  cnt_q;
  logic [19:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sh_q  <= wide ? bin : {bin[7:0], 8'h00};
      bcd_q <= '0;
      cnt_q <= wide ? 5'd16 : 5'd8;
    end else if (cnt_q != 5'd0) begin
      {bcd_q, sh_q} <= {adj[18:0], sh_q, 1'b0};
      cnt_q         <= cnt_q - 5'd1;
    end
  end

  // High during the final shift; bcd holds the result from the next cycle on.
  assign done = (cnt_q == 5'd1);
  assign bcd  = bcd_q;

endmodule

// File: rtl/time_display_driver.sv
// Snapshots time/date fields, converts them to BCD with one shared engine and
// scans an 8-digit active-low seven-segment display showing a time or date page.
module time_display_driver
  import time_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  hh,
  input  logic [7:0]  mm,
  input  logic [7:0]  ss,
  input  logic [7:0]  DD,
  input  logic [7:0]  MM,
  input  logic [15:0] YYYY,
  input  logic        update,
  input  logic        show_date,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  state_t      state_q, state_d;
  logic [2:0]  fld_q, fld_d;
  logic        pending_q, pending_d;
  logic        take, start, store, commit;

  logic [7:0]  snap_ss_q, snap_mm_q, snap_hh_q, snap_dd_q, snap_mo_q;
  logic [15:0] snap_yy_q;
  logic [15:0] fld_val;

  logic        eng_done;
  logic [19:0] eng_bcd;
  logic        over8, over16;
  digit_t      new_lo, new_hi;

  // Staging shift chain: index 0 holds the most recently converted field.
  logic [4:0][4:0]  stg_lo_q, stg_hi_q;
  logic [15:0][4:0] buf_q;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q, idx_d;
  logic             page_q, page_d, tc, dp_lit;
  digit_t           cur;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  always_comb begin
    unique case (fld_q)
      FLD_SS:  fld_val = {8'h00, snap_ss_q};
      FLD_MM:  fld_val = {8'h00, snap_mm_q};
      FLD_HH:  fld_val = {8'h00, snap_hh_q};
      FLD_DD:  fld_val = {8'h00, snap_dd_q};
      FLD_MO:  fld_val = {8'h00, snap_mo_q};
      default: fld_val = snap_yy_q;
    endcase
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .wide  (fld_q == FLD_YY),
    .bin   (fld_val),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  // A nonzero hundreds (or ten-thousands) nibble means the field does not fit.
  assign over8  = |eng_bcd[11:8];
  assign over16 = |eng_bcd[19:16];
  assign new_lo = over8 ? DIG_DASH : digit_t'({1'b0, eng_bcd[3:0]});
  assign new_hi = over8 ? DIG_DASH : digit_t'({1'b0, eng_bcd[7:4]});

  always_comb begin
    state_d   = state_q;
    fld_d     = fld_q;
    pending_d = pending_q;
    take      = 1'b0;
    start     = 1'b0;
    store     = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (update) begin
          take    = 1'b1;
          fld_d   = FLD_SS;
          state_d = StLoad;
        end
      end
      StLoad: begin
        start   = 1'b1;
        store   = (fld_q != FLD_SS);
        state_d = StShift;
        if (update) pending_d = 1'b1;
      end
      StShift: begin
        if (update) pending_d = 1'b1;
        if (eng_done) begin
          if (fld_q == FLD_YY) begin
            state_d = StCommit;
          end else begin
            fld_d   = fld_q + 3'd1;
            state_d = StLoad;
          end
        end
      end
      StCommit: begin
        commit    = 1'b1;
        pending_d = 1'b0;
        if (pending_q || update) begin
          take    = 1'b1;
          fld_d   = FLD_SS;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      fld_q     <= FLD_SS;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fld_q     <= fld_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_ss_q <= '0;
      snap_mm_q <= '0;
      snap_hh_q <= '0;
      snap_dd_q <= '0;
      snap_mo_q <= '0;
      snap_yy_q <= '0;
      stg_lo_q  <= {5{DIG_BLANK}};
      stg_hi_q  <= {5{DIG_BLANK}};
      buf_q     <= {16{DIG_BLANK}};
    end else begin
      if (take) begin
        snap_ss_q <= ss;
        snap_mm_q <= mm;
        snap_hh_q <= hh;
        snap_dd_q <= DD;
        snap_mo_q <= MM;
        snap_yy_q <= YYYY;
      end
      if (store) begin
        stg_lo_q <= {stg_lo_q[3:0], new_lo};
        stg_hi_q <= {stg_hi_q[3:0], new_hi};
      end
      if (commit) begin
        // After five stores: [4]=ss, [3]=mm, [2]=hh, [1]=DD, [0]=MM.
        buf_q[0]  <= stg_lo_q[4];
        buf_q[1]  <= stg_hi_q[4];
        buf_q[2]  <= stg_lo_q[3];
        buf_q[3]  <= stg_hi_q[3];
        buf_q[4]  <= stg_lo_q[2];
        buf_q[5]  <= stg_hi_q[2];
        buf_q[6]  <= DIG_BLANK;
        buf_q[7]  <= DIG_BLANK;
        for (int i = 0; i < 4; i++) begin
          buf_q[8+i] <= over16 ? DIG_DASH : digit_t'({1'b0, eng_bcd[4*i +: 4]});
        end
        buf_q[12] <= stg_lo_q[0];
        buf_q[13] <= stg_hi_q[0];
        buf_q[14] <= stg_lo_q[1];
        buf_q[15] <= stg_hi_q[1];
      end
    end
  end

  // Scan outputs are built from next-state index/page so an, seg, dp move together.
  always_comb begin
    tc     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    idx_d  = tc ? idx_q + 3'd1 : idx_q;
    page_d = (tc && idx_q == 3'd7) ? show_date : page_q;
    cur    = buf_q[{page_d, idx_d}];
    dp_lit = page_d ? (idx_d == 3'd6 || idx_d == 3'd4) : (idx_d == 3'd4 || idx_d == 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      page_q <= 1'b0;
      an_q   <= 8'hFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= tc ? '0 : cnt_q + 1'b1;
      idx_q  <= idx_d;
      page_q <= page_d;
      an_q   <= ~(8'b1 << idx_d);
      seg_q  <= seg_of(cur);
      dp_q   <= ~dp_lit;
    end
  end

  assign busy = (state_q != StIdle);
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver: fixed vectors, multi-cycle
// corner cases and random fields checked against an arithmetic display model.
module tb_time_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  hh, mm, ss, dd, mo;
  logic [15:0] yy;
  logic        update = 1'b0;
  logic        show_date = 1'b0;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cyc0 = 0;

  time_display_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .DD        (dd),
    .MM        (mo),
    .YYYY      (yy),
    .update    (update),
    .show_date (show_date),
    .busy      (busy),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int h, m, s, d, mo, y;
    logic [7:0][6:0] tseg;
    logic [7:0][6:0] dseg;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] lut(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // 10 = dash, 11 = blank.
  function automatic int two(input int v, input bit tens);
    if (v > 99) return 10;
    return tens ? v / 10 : v % 10;
  endfunction

  function automatic int model_digit(input bit date, input int i, input int h, input int m,
                                     input int s, input int d, input int mo_v, input int y);
    int div;
    if (!date) begin
      case (i)
        0: return two(s, 0);  1: return two(s, 1);
        2: return two(m, 0);  3: return two(m, 1);
        4: return two(h, 0);  5: return two(h, 1);
        default: return 11;
      endcase
    end
    case (i)
      7: return two(d, 1);     6: return two(d, 0);
      5: return two(mo_v, 1);  4: return two(mo_v, 0);
      default: begin
        if (y > 9999) return 10;
        div = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
        return (y / div) % 10;
      end
    endcase
  endfunction

  function automatic logic [7:0][6:0] model_frame(input bit date, input int h, input int m,
                                                  input int s, input int d, input int mo_v,
                                                  input int y);
    logic [7:0][6:0] r;
    for (int i = 0; i < 8; i++) r[i] = lut(model_digit(date, i, h, m, s, d, mo_v, y));
    return r;
  endfunction

  function automatic logic dp_exp(input bit date, input int i);
    return date ? !(i == 6 || i == 4) : !(i == 4 || i == 2);
  endfunction

  task automatic set_in(input int h, input int m, input int s, input int d, input int mo_v,
                        input int y);
    hh = 8'(h); mm = 8'(m); ss = 8'(s); dd = 8'(d); mo = 8'(mo_v); yy = 16'(y);
  endtask

  // Wait for the display to newly enter digit i (a transition, not a stale dwell).
  task automatic wait_digit(input int i, output bit ok);
    logic [7:0] tgt, prev;
    tgt = ~(8'b1 << i);
    prev = an;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (an == tgt && prev != tgt) ok = 1'b1;
      prev = an;
    end
  endtask

  task automatic check_frame(input string name, input bit date, input logic [7:0][6:0] exp,
                             input int ndig);
    bit ok;
    for (int i = 0; i < ndig; i++) begin
      wait_digit(i, ok);
      if (!ok) begin
        chk($sformatf("%s d%0d timeout", name, i), 0, 1);
        return;
      end
      chk($sformatf("%s d%0d seg", name, i), int'(seg), int'(exp[i]));
      chk($sformatf("%s d%0d dp", name, i), int'(dp), int'(dp_exp(date, i)));
    end
  endtask

  task automatic conv_and_count(input string name);
    int n;
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, n, 63);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    show_date = 1'b0;
    set_in(v.h, v.m, v.s, v.d, v.mo, v.y);
    conv_and_count(name);
    repeat (2) @(negedge clk);
    check_frame({name, " time"}, 1'b0, v.tseg, 8);
    show_date = 1'b1;
    check_frame({name, " date"}, 1'b1, v.dseg, 8);
    show_date = 1'b0;
  endtask

  vec_t vecs[3];
  vec_t rv;
  logic [7:0] an_e;
  logic [7:0][6:0] blank_f;
  int nb;

  initial begin
    vecs[0] = '{13, 5, 9, 29, 2, 2024,
                {7'h7F, 7'h7F, 7'h79, 7'h30, 7'h40, 7'h12, 7'h40, 7'h10},
                {7'h24, 7'h10, 7'h40, 7'h24, 7'h24, 7'h40, 7'h24, 7'h19}};
    vecs[1] = '{150, 59, 0, 31, 12, 12000,
                {7'h7F, 7'h7F, 7'h3F, 7'h3F, 7'h12, 7'h10, 7'h40, 7'h40},
                {7'h30, 7'h79, 7'h79, 7'h24, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[2] = '{23, 100, 99, 7, 100, 9999,
                {7'h7F, 7'h7F, 7'h24, 7'h30, 7'h3F, 7'h3F, 7'h10, 7'h10},
                {7'h40, 7'h78, 7'h3F, 7'h3F, 7'h10, 7'h10, 7'h10, 7'h10}};
    blank_f = {8{7'h7F}};

    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset an", int'(an), 'hFF);
    chk("reset seg", int'(seg), 'h7F);
    chk("reset dp", int'(dp), 1);
    rst = 1'b0;

    // Idle scan: digit index advances every REFRESH_DIV clocks, all blank.
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      an_e = ~(8'b1 << ((n / 4) % 8));
      chk($sformatf("idle an c%0d", n), int'(an), int'(an_e));
      chk($sformatf("idle seg c%0d", n), int'(seg), 'h7F);
      chk($sformatf("idle dp c%0d", n), int'(dp), int'(dp_exp(0, (n / 4) % 8)));
      chk($sformatf("idle busy c%0d", n), int'(busy), 0);
    end

    for (int i = 0; i < 3; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Request while busy: second conversion chained straight after the first commit.
    show_date = 1'b0;
    set_in(1, 2, 3, 4, 5, 2001);
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
    cyc0 = cyc;
    repeat (4) @(negedge clk);
    set_in(11, 22, 33, 14, 6, 1999);
    while (cyc - cyc0 < 9) @(negedge clk);
    update = 1'b1;
    @(negedge clk) update = 1'b0;
    while (cyc - cyc0 < 63) @(negedge clk);
    chk("multi busy at E63", int'(busy), 1);
    set_in(44, 55, 6, 1, 1, 1900);
    check_frame("multi first", 1'b0, model_frame(0, 1, 2, 3, 4, 5, 2001), 6);
    while (busy === 1'b1 && cyc - cyc0 < 300) @(negedge clk);
    chk("multi busy fall", cyc - cyc0, 126);
    repeat (2) @(negedge clk);
    check_frame("multi second", 1'b0, model_frame(0, 11, 22, 33, 14, 6, 1999), 8);

    // Reset in the middle of a conversion.
    set_in(12, 34, 56, 9, 9, 1234);
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
    cyc0 = cyc;
    while (cyc - cyc0 < 29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", int'(busy), 0);
    chk("midrst an", int'(an), 'hFF);
    chk("midrst seg", int'(seg), 'h7F);
    chk("midrst dp", int'(dp), 1);
    rst = 1'b0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    chk("midrst no busy after", nb, 0);
    check_frame("midrst time", 1'b0, blank_f, 8);
    show_date = 1'b1;
    check_frame("midrst date", 1'b1, blank_f, 8);
    show_date = 1'b0;

    // Random fields, including out-of-range values, against the model.
    for (int r = 0; r < 6; r++) begin
      rv.h  = int'($urandom_range(0, 130));
      rv.m  = int'($urandom_range(0, 110));
      rv.s  = int'($urandom_range(0, 110));
      rv.d  = int'($urandom_range(0, 105));
      rv.mo = int'($urandom_range(0, 105));
      rv.y  = int'($urandom_range(0, 10100));
      rv.tseg = model_frame(0, rv.h, rv.m, rv.s, rv.d, rv.mo, rv.y);
      rv.dseg = model_frame(1, rv.h, rv.m, rv.s, rv.d, rv.mo, rv.y);
      run_vec($sformatf("rnd%0d", r), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
